// File: rtl/kara_pkg.sv
// Shared widths, FSM state type and the Karatsuba overlap combine for kara_seq_mult_ctrl.
package kara_pkg;

    localparam int unsigned KARA_M = 6;
    localparam int unsigned OPW    = 2 * KARA_M;
    localparam int unsigned PPW    = 2 * KARA_M - 1;
    localparam int unsigned RW     = 4 * KARA_M - 1;

    typedef enum logic [2:0] {
        StIdle,
        StMulLo,
        StMulHi,
        StMulMid,
        StDone
    } kara_state_t;

    // The middle term is recovered as P_mid ^ P_lo ^ P_hi, because subtraction over GF(2) is XOR.
    function automatic logic [RW-1:0] kara_combine(input logic [PPW-1:0] p_lo,
                                                   input logic [PPW-1:0] p_hi,
                                                   input logic [PPW-1:0] p_mid);
        logic [RW-1:0] w_lo;
        logic [RW-1:0] w_mid;
        logic [RW-1:0] w_hi;
        w_lo  = {{(RW - PPW){1'b0}}, p_lo};
        w_mid = {{(RW - PPW){1'b0}}, p_mid ^ p_lo ^ p_hi};
        w_hi  = {{(RW - PPW){1'b0}}, p_hi};
        return w_lo ^ (w_mid << KARA_M) ^ (w_hi << OPW);
    endfunction

endpackage

// File: rtl/gf2_clmul_core.sv
// Combinational M x M carry-less (GF(2)) multiplier built as an AND/XOR array.
module gf2_clmul_core #(
    parameter int unsigned M = 6
) (
    input  logic [M-1:0]   i_a,
    input  logic [M-1:0]   i_b,
    output logic [2*M-2:0] o_p
);

    logic [2*M-2:0] w_a_ext;

    assign w_a_ext = {{(M - 1){1'b0}}, i_a};

    always_comb begin
        o_p = '0;
        for (int i = 0; i < M; i++) begin
            if (i_b[i]) begin
                o_p = o_p ^ (w_a_ext << i);
            end
        end
    end

endmodule

// File: rtl/kara_seq_mult_ctrl.sv
// Sequential one-level Karatsuba GF(2) multiplier sharing one M x M core over three states.
// Optional KARA_ZERO_SKIP_EN: a zero operand goes straight from IDLE to DONE with a zero product.
module kara_seq_mult_ctrl
    import kara_pkg::*;
#(
    parameter int unsigned M = KARA_M
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] a_in,
    input  logic [OPW-1:0] b_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [RW-1:0]  c_out,
    output logic           busy
);

    kara_state_t    r_state;
    kara_state_t    w_state_d;
    logic [OPW-1:0] r_a;
    logic [OPW-1:0] r_b;
    logic [PPW-1:0] r_p_lo;
    logic [PPW-1:0] r_p_hi;
    logic [RW-1:0]  r_c;
    logic [M-1:0]   w_core_a;
    logic [M-1:0]   w_core_b;
    logic [PPW-1:0] w_core_p;
    logic           w_zero_op;

`ifdef KARA_ZERO_SKIP_EN
    assign w_zero_op = (a_in == '0) || (b_in == '0);
`else
    assign w_zero_op = 1'b0;
`endif

    gf2_clmul_core #(
        .M (M)
    ) u_core (
        .i_a (w_core_a),
        .i_b (w_core_b),
        .o_p (w_core_p)
    );

    // Core operand select depends only on state; idle states feed zeros to keep the array quiet.
    always_comb begin
        w_state_d = r_state;
        w_core_a  = '0;
        w_core_b  = '0;
        unique case (r_state)
            StIdle: begin
                if (in_valid) begin
                    w_state_d = w_zero_op ? StDone : StMulLo;
                end
            end
            StMulLo: begin
                w_core_a  = r_a[M-1:0];
                w_core_b  = r_b[M-1:0];
                w_state_d = StMulHi;
            end
            StMulHi: begin
                w_core_a  = r_a[OPW-1:M];
                w_core_b  = r_b[OPW-1:M];
                w_state_d = StMulMid;
            end
            StMulMid: begin
                w_core_a  = r_a[M-1:0] ^ r_a[OPW-1:M];
                w_core_b  = r_b[M-1:0] ^ r_b[OPW-1:M];
                w_state_d = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_a     <= '0;
            r_b     <= '0;
            r_p_lo  <= '0;
            r_p_hi  <= '0;
            r_c     <= '0;
        end else begin
            r_state <= w_state_d;
            unique case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_a <= a_in;
                        r_b <= b_in;
                        if (w_zero_op) begin
                            r_c <= '0;
                        end
                    end
                end
                StMulLo:  r_p_lo <= w_core_p;
                StMulHi:  r_p_hi <= w_core_p;
                StMulMid: r_c    <= kara_combine(r_p_lo, r_p_hi, w_core_p);
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == StIdle);
    assign out_valid = (r_state == StDone);
    assign busy      = (r_state != StIdle);
    assign c_out     = r_c;

endmodule

// File: tb/tb_kara_seq_mult_ctrl.sv
// Directed and random checks of kara_seq_mult_ctrl against a plain shift-XOR reference multiply.
module tb_kara_seq_mult_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] a_in;
    logic [11:0] b_in;
    logic        out_valid;
    logic        out_ready;
    logic [22:0] c_out;
    logic        busy;

    int n_checks;
    int n_fail;

    kara_seq_mult_ctrl u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c_out     (c_out),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [22:0] ref_clmul(input logic [11:0] a, input logic [11:0] b);
        logic [22:0] acc;
        acc = '0;
        for (int i = 0; i < 12; i++) begin
            if (b[i]) acc = acc ^ ({11'b0, a} << i);
        end
        return acc;
    endfunction

    function automatic int exp_latency(input logic [11:0] a, input logic [11:0] b);
`ifdef KARA_ZERO_SKIP_EN
        if (a == 12'h000 || b == 12'h000) return 1;
`endif
        return 4;
    endfunction

    // Presents one operand pair from IDLE and waits (bounded) for out_valid; leaves the DUT in DONE.
    task automatic start_op(input string tag, input logic [11:0] a, input logic [11:0] b,
                            input logic [22:0] exp_c, input int exp_lat);
        int cyc;
        @(negedge clk);
        in_valid = 1'b1;
        a_in     = a;
        b_in     = b;
        cyc      = 0;
        do begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (cyc == 1) in_valid = 1'b0;
        end while (!out_valid && cyc < 20);
        check_eq({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
        check_eq({tag, "_c_out"}, 64'(c_out), 64'(exp_c));
    endtask

    // With out_ready high, DONE lasts one cycle and the next edge returns to IDLE.
    task automatic run_op(input string tag, input logic [11:0] a, input logic [11:0] b,
                          input logic [22:0] exp_c, input int exp_lat);
        start_op(tag, a, b, exp_c, exp_lat);
        @(posedge clk);
        @(negedge clk);
        check_eq({tag, "_idle_after"}, 64'({out_valid, in_ready, busy}), 64'(3'b010));
    endtask

    initial begin
        logic [11:0] ra;
        logic [11:0] rb;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a_in      = '0;
        b_in      = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("reset_in_ready", 64'(in_ready), 64'd1);
        check_eq("reset_out_valid", 64'(out_valid), 64'd0);
        check_eq("reset_busy", 64'(busy), 64'd0);
        check_eq("reset_c_out", 64'(c_out), 64'd0);
        rst_n = 1'b1;

        run_op("basic", 12'h001, 12'h001, 23'h000001, 4);
        run_op("mid_overlap", 12'h003, 12'h003, 23'h000005, 4);
        run_op("high_half", 12'h040, 12'h040, 23'h001000, 4);
        run_op("full_width", 12'hFFF, 12'hFFF, 23'h555555, 4);
        run_op("asym", 12'h801, 12'h003, 23'h001803, 4);

        // Backpressure: hold out_ready low and offer competing operands during DONE.
        out_ready = 1'b0;
        start_op("bp", 12'hFFF, 12'h001, 23'h000FFF, 4);
        in_valid = 1'b1;
        a_in     = 12'h555;
        b_in     = 12'h777;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_eq("bp_hold", 64'({out_valid, in_ready, busy, c_out}),
                     64'({1'b1, 1'b0, 1'b1, 23'h000FFF}));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("bp_release_idle", 64'({out_valid, in_ready, busy}), 64'(3'b010));
        check_eq("bp_c_kept", 64'(c_out), 64'h000FFF);

        // Reset while in MUL_HI discards the operation and clears the held product.
        @(negedge clk);
        in_valid = 1'b1;
        a_in     = 12'hABC;
        b_in     = 12'h123;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("pre_reset_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_eq("midreset_state", 64'({out_valid, in_ready, busy}), 64'(3'b010));
        check_eq("midreset_c_out", 64'(c_out), 64'd0);
        rst_n = 1'b1;

        run_op("zero_a", 12'h000, 12'h123, 23'h000000, exp_latency(12'h000, 12'h123));
        run_op("after_zero", 12'h123, 12'h001, 23'h000123, 4);
        run_op("zero_b", 12'h0F0, 12'h000, 23'h000000, exp_latency(12'h0F0, 12'h000));

        for (int n = 0; n < 1000; n++) begin
            ra = 12'($urandom);
            rb = 12'($urandom);
            run_op("rand", ra, rb, ref_clmul(ra, rb), exp_latency(ra, rb));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
